// File: rtl/dmem_bus_adapter.sv
// Data-memory bus adapter: turns one LSU access into a single valid/ready
// request plus response transaction and stalls the pipeline until it completes.
module dmem_bus_adapter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_wmask,
    output logic        stall,
    output logic [31:0] core_rdata,
    output logic        core_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wmask,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata,
    input  logic        bus_rsp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic        valid_q, valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (core_req) begin
                    addr_d  = core_addr;
                    we_d    = core_we;
                    wdata_d = core_wdata;
                    wmask_d = core_we ? core_wmask : 4'b0000;
                    cnt_d   = 16'd0;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 16'd1;
                // Timeout wins over a late handshake; a response here is never a completion.
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = 32'd0;
                    end
                end else if (bus_req_ready) begin
                    state_d = S_WAIT;
                    valid_d = 1'b0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (bus_rsp_valid) begin
                    state_d = S_DONE;
                    err_d   = bus_rsp_err;
                    if (!we_q) begin
                        rdata_d = bus_rsp_err ? 32'd0 : bus_rsp_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = 32'd0;
                    end
                end
            end
            default: begin
                // The request still on core_req is the one just finished.
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            wmask_q <= 4'b0000;
            valid_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign stall         = core_req & (state_q != S_DONE);
    assign core_rdata    = rdata_q;
    assign core_err      = (state_q == S_DONE) & err_q;
    assign bus_req_valid = valid_q;
    assign bus_addr      = addr_q;
    assign bus_we        = we_q;
    assign bus_wdata     = wdata_q;
    assign bus_wmask     = wmask_q;

endmodule

// File: doc/dmem_bus_adapter.md
# dmem_bus_adapter

Data-memory bus adapter sitting directly downstream of the load/store unit in the RV32I core. It accepts the word-aligned address, shifted write data and byte write mask the LSU produces in EX, runs one transaction on a valid/ready request bus with a separate response channel, and stalls the pipeline until the transaction completes. It returns the raw 32-bit read word that the LSU consumes in MEM as `data_read_mem`, held stable until the next load completes, and flags bus errors and timeouts.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles spent in REQ+WAIT before abort; legal range 1..65535.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `core_req`  in  1  EX stage holds a load or store (`idex_L | idex_wmem`).
- `core_we`  in  1  1 = store, 0 = load.
- `core_addr`  in  32  word address from LSU; bits [1:0] are always 0.
- `core_wdata`  in  32  byte-lane-aligned store data.
- `core_wmask`  in  4  byte write enables; ignored for loads.
- `stall`  out  1  freeze the pipeline this cycle.
- `core_rdata`  out  32  last completed read word (to LSU `data_read_mem`).
- `core_err`  out  1  one-cycle pulse: last transaction errored or timed out.
- `bus_req_valid`  out  1  request valid.
- `bus_req_ready`  in  1  slave accepts request.
- `bus_addr`  out  32  registered request address.
- `bus_we`  out  1  registered write flag.
- `bus_wdata`  out  32  registered write data.
- `bus_wmask`  out  4  registered byte mask; forced to 4'b0000 for loads.
- `bus_rsp_valid`  in  1  response valid (one-cycle pulse per request).
- `bus_rsp_rdata`  in  32  read data; don't-care for stores.
- `bus_rsp_err`  in  1  slave error, qualified by `bus_rsp_valid`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if `core_req`, capture `core_addr/core_we/core_wdata/core_wmask` into request registers, clear timeout counter, go REQ. `bus_rsp_valid` ignored.
- REQ: `bus_req_valid`=1, request registers stable. On `bus_req_ready` -> WAIT. If `bus_req_ready` and `bus_rsp_valid` coincide in the same cycle, the response is ignored; a response counts only in WAIT.
- WAIT: on `bus_rsp_valid` -> DONE. For a load, `core_rdata` <= `bus_rsp_rdata`, or 0 if `bus_rsp_err`. For a store, `core_rdata` is unchanged. Err flag <= `bus_rsp_err`.
- Timeout: a 16-bit counter increments each cycle in REQ or WAIT. When it reaches `TIMEOUT_CYCLES - 1` without completion -> DONE with err flag = 1. `bus_req_valid` drops, load `core_rdata` <= 0, and any later response is discarded.
- DONE: `stall`=0, `core_err` = err flag; the pipeline advances on this edge. Next state is always IDLE, even if `core_req` is still high: that request is the one just completed.
- `stall` = `core_req` & (state != DONE). It is combinational from `core_req` and state, and is never asserted when `core_req`=0.
- Misaligned accesses arrive from the LSU as two consecutive `core_req` instructions and are handled as two independent transactions. The second-half read data overwrites `core_rdata` only after the LSU has registered the first half in MEM/WB.

## Timing
- Reset values: state IDLE; `stall`=0 while `core_req`=0; `core_rdata`=0; `core_err`=0; `bus_req_valid`=0; `bus_addr`/`bus_wdata`=0; `bus_we`=0; `bus_wmask`=0; counter 0.
- Minimum transaction (ready in cycle 1, response in cycle 2):
  - cycle 0: IDLE with `stall`=1.
  - cycle 1: REQ.
  - cycle 2: WAIT, response arrives.
  - cycle 3: DONE with `stall`=0 and `core_rdata` valid.
  - Total: 3 stall cycles.
- Each extra wait cycle of `bus_req_ready` or `bus_rsp_valid` adds one stall cycle.
- Back-to-back accesses: DONE -> IDLE leaves one idle cycle before the next `bus_req_valid`.
- `bus_*` request outputs are registered and stable from REQ entry until the ready handshake.
- `core_rdata` changes only on the DONE-entry edge of a load (or at reset). It holds through any number of subsequent stall or idle cycles.
- Reset mid-transaction: the next edge returns to IDLE and deasserts `bus_req_valid`. Responses arriving afterwards are ignored.

## Test plan
- Load, zero wait: `core_req`=1, `core_we`=0, addr 0x100. Ready in REQ, response 0xA5A5_1234 the next cycle -> `stall` high for exactly 3 cycles, `bus_wmask`=0, `core_rdata`=0xA5A5_1234 in DONE, `core_err`=0.
- Store with backpressure: addr 0x204, wdata 0x0000_BE00, mask 4'b0010. Ready delayed 4 cycles, response 2 cycles later -> bus fields held constant throughout, `stall` high for 8 cycles, `core_rdata` unchanged.
- Error response: load where `bus_rsp_err`=1 -> `core_err` pulses 1 cycle in DONE and `core_rdata`=0.
- Timeout: `TIMEOUT_CYCLES`=8, slave never ready -> DONE after 8 cycles in REQ, `core_err`=1. A late response injected in IDLE has no effect.
- Misaligned pair: two back-to-back loads to 0x300 then 0x304 (responses 0x1122_3344, 0x5566_7788) -> two separate transactions with one idle cycle between them. `core_rdata` = 0x1122_3344 then 0x5566_7788, each held until the next DONE.
- Reset in WAIT: assert `reset` for one cycle -> state IDLE and `bus_req_valid`=0 next cycle. A response pulse 2 cycles later is ignored and `core_rdata`=0.
